// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Package : pll_seq_pkg
// Brief   : State encoding and status-counter widths for pll_reset_sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    localparam int RETRY_W = 8;
    localparam int LOSS_W  = 16;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (((a > b) ? a : b) > c) ? ((a > b) ? a : b) : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lock_sync.sv
// ============================================================================
// Module : lock_sync
// Brief  : Generic 2-flop synchronizer with synchronous reset to zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module : pll_reset_sequencer
// Brief  : Pulses PLL reset, waits for lock with timeout and retry budget,
//          qualifies lock stability and re-sequences on lock loss.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic               aclk_i,
    input  logic               rst_i,
    input  logic               locked_i,
    input  logic               restart_i,
    output logic               pll_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [2:0]         state_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [LOSS_W-1:0]  loss_cnt_o
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               pll_rst_q, ready_q, fail_q;
    logic               lock_s;
    logic [RETRY_W-1:0] retry_inc;

    lock_sync #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (aclk_i),
        .rst_i (rst_i),
        .d_i   (locked_i),
        .q_o   (lock_s)
    );

    assign retry_inc = retry_q + RETRY_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (restart_i) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle takes precedence.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                        if (loss_q != {LOSS_W{1'b1}}) begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
            ready_q   <= (state_d == ST_READY);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign ready_o     = ready_q;
    assign fail_o      = fail_q;
    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign loss_cnt_o  = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module : tb_pll_reset_sequencer
// Brief  : Directed scenarios plus randomized run against a countdown model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;
    localparam int READY_DELAY   = STABLE_CYCLES + 3;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        locked_i = 1'b0;
    logic        restart_i = 1'b0;
    logic        pll_rst_o, ready_o, fail_o;
    logic [2:0]  state_o;
    logic [7:0]  retry_cnt_o;
    logic [15:0] loss_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .aclk_i      (clk),
        .rst_i       (rst_i),
        .locked_i    (locked_i),
        .restart_i   (restart_i),
        .pll_rst_o   (pll_rst_o),
        .ready_o     (ready_o),
        .fail_o      (fail_o),
        .state_o     (state_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o)
    );

    // Reference: phase number plus cycles remaining in that phase, and a
    // two-deep history of locked_i standing in for the synchronizer delay.
    int   m_phase = 0;
    int   m_left = RST_CYCLES;
    int   m_retries = 0;
    int   m_losses = 0;
    logic [1:0] m_hist = 2'b00;

    always @(posedge clk) begin : model
        int   ph, left, rt, ls;
        logic lk;
        ph = m_phase; left = m_left; rt = m_retries; ls = m_losses;
        lk = m_hist[1];
        if (rst_i) begin
            ph = 0; left = RST_CYCLES; rt = 0; ls = 0;
        end else if (restart_i) begin
            ph = 0; left = RST_CYCLES; rt = 0;
        end else begin
            case (ph)
                0: if (left == 1) begin ph = 1; left = LOCK_TIMEOUT; end else left = left - 1;
                1: begin
                    if (lk) begin
                        ph = 2; left = STABLE_CYCLES;
                    end else if (left == 1) begin
                        rt = rt + 1;
                        ph = (rt == MAX_RETRIES) ? 4 : 0;
                        left = RST_CYCLES;
                    end else begin
                        left = left - 1;
                    end
                end
                2: begin
                    if (!lk) begin ph = 1; left = LOCK_TIMEOUT; end
                    else if (left == 1) ph = 3;
                    else left = left - 1;
                end
                3: if (!lk) begin
                    ph = 0; left = RST_CYCLES;
                    ls = (ls < 65535) ? ls + 1 : 65535;
                end
                default: ;
            endcase
        end
        m_phase   <= ph;
        m_left    <= left;
        m_retries <= rt;
        m_losses  <= ls;
        m_hist    <= rst_i ? 2'b00 : {m_hist[0], locked_i};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; restart_i = 1'b0; locked_i = 1'b0;
        repeat (3) tick();
        n_vec++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        n_vec++; if (pll_rst_o !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst_o); end
        n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        n_vec++; if (fail_o !== 1'b0) begin n_err++; $display("FAIL reset_fail got=%b exp=0", fail_o); end
        n_vec++; if (retry_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt_o); end
        n_vec++; if (loss_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_loss got=%0d exp=0", loss_cnt_o); end
        rst_i = 1'b0;
    endtask

    // Continues directly from test_reset: the current sample is the first
    // one after the last reset edge.
    task automatic test_first_lock();
        int hi = 1;
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pll_rst_o) hi++;
        end
        n_vec++; if (hi != RST_CYCLES) begin n_err++; $display("FAIL first_pll_rst_width got=%0d exp=%0d", hi, RST_CYCLES); end
        locked_i = 1'b1;
        while (!ready_o && n < 40) begin tick(); n++; end
        n_vec++; if (n != READY_DELAY) begin n_err++; $display("FAIL first_ready_delay got=%0d exp=%0d", n, READY_DELAY); end
        n_vec++; if ({state_o, retry_cnt_o, loss_cnt_o} !== {3'd3, 8'd0, 16'd0}) begin
            n_err++; $display("FAIL first_ready_status got state=%0d retry=%0d loss=%0d exp 3/0/0", state_o, retry_cnt_o, loss_cnt_o);
        end
    endtask

    task automatic test_no_lock();
        logic [9:0] exp_v;
        int         r;
        rst_i = 1'b1; locked_i = 1'b0; restart_i = 1'b0;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            r = i / (RST_CYCLES + LOCK_TIMEOUT);
            exp_v = {(i >= 60) || ((i % (RST_CYCLES + LOCK_TIMEOUT)) < RST_CYCLES),
                     i >= 60, 8'((r > MAX_RETRIES) ? MAX_RETRIES : r)};
            n_vec++;
            if ({pll_rst_o, fail_o, retry_cnt_o} !== exp_v) begin
                n_err++;
                $display("FAIL no_lock cycle %0d got pll/fail/retry=%b/%b/%0d exp=%b/%b/%0d", i,
                         pll_rst_o, fail_o, retry_cnt_o, exp_v[9], exp_v[8], exp_v[7:0]);
            end
            tick();
        end
        n_vec++; if (state_o !== 3'd4) begin n_err++; $display("FAIL no_lock_state got=%0d exp=4", state_o); end
    endtask

    task automatic test_stable_glitch();
        int   n = 0;
        logic saw_wait = 1'b0;
        logic saw_pll = 1'b0;
        rst_i = 1'b1; locked_i = 1'b1;
        tick();
        rst_i = 1'b0;
        while (state_o !== 3'd2 && n < 40) begin tick(); n++; end
        n_vec++; if (state_o !== 3'd2) begin n_err++; $display("FAIL glitch_reach_stable got=%0d exp=2", state_o); end
        locked_i = 1'b0;
        tick();
        locked_i = 1'b1;
        n = 0;
        while (!ready_o && n < 40) begin
            tick(); n++;
            if (state_o == 3'd1) saw_wait = 1'b1;
            if (pll_rst_o) saw_pll = 1'b1;
        end
        n_vec++; if (n != READY_DELAY) begin n_err++; $display("FAIL glitch_ready_delay got=%0d exp=%0d", n, READY_DELAY); end
        n_vec++; if ({saw_wait, saw_pll} !== 2'b10) begin n_err++; $display("FAIL glitch_path got wait/pll=%b/%b exp=1/0", saw_wait, saw_pll); end
        n_vec++; if (retry_cnt_o !== 8'd0) begin n_err++; $display("FAIL glitch_retry got=%0d exp=0", retry_cnt_o); end
    endtask

    // Low window is sized so the relock lands on the lock-timeout cycle.
    task automatic test_lock_loss();
        int n = 0;
        int hi = 0;
        locked_i = 1'b0;
        while (ready_o && n < 10) begin tick(); n++; end
        n_vec++; if (n != 3) begin n_err++; $display("FAIL loss_ready_fall got=%0d exp=3", n); end
        n_vec++; if (loss_cnt_o !== 16'd1) begin n_err++; $display("FAIL loss_count got=%0d exp=1", loss_cnt_o); end
        for (int i = 3; i < 20; i++) begin
            if (pll_rst_o) hi++;
            tick();
        end
        n_vec++; if (hi != RST_CYCLES) begin n_err++; $display("FAIL loss_pll_rst_width got=%0d exp=%0d", hi, RST_CYCLES); end
        locked_i = 1'b1;
        n = 0;
        while (!ready_o && n < 40) begin tick(); n++; end
        n_vec++; if (n != READY_DELAY) begin n_err++; $display("FAIL loss_relock_delay got=%0d exp=%0d", n, READY_DELAY); end
        n_vec++; if ({retry_cnt_o, loss_cnt_o} !== {8'd0, 16'd1}) begin
            n_err++; $display("FAIL loss_status got retry=%0d loss=%0d exp 0/1", retry_cnt_o, loss_cnt_o);
        end
    endtask

    task automatic test_restart();
        int n = 0;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        locked_i = 1'b0;
        n_vec++;
        if ({state_o, retry_cnt_o, fail_o, ready_o, loss_cnt_o} !== {3'd0, 8'd0, 1'b0, 1'b0, 16'd1}) begin
            n_err++; $display("FAIL restart_ready got state=%0d retry=%0d fail=%b ready=%b loss=%0d exp 0/0/0/0/1",
                              state_o, retry_cnt_o, fail_o, ready_o, loss_cnt_o);
        end
        while (!fail_o && n < 100) begin tick(); n++; end
        n_vec++; if ({fail_o, retry_cnt_o} !== {1'b1, 8'd3}) begin n_err++; $display("FAIL restart_reach_fail got fail=%b retry=%0d exp 1/3", fail_o, retry_cnt_o); end
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        n_vec++;
        if ({state_o, retry_cnt_o, fail_o, pll_rst_o, loss_cnt_o} !== {3'd0, 8'd0, 1'b0, 1'b1, 16'd1}) begin
            n_err++; $display("FAIL restart_fail got state=%0d retry=%0d fail=%b pll=%b loss=%0d exp 0/0/0/1/1",
                              state_o, retry_cnt_o, fail_o, pll_rst_o, loss_cnt_o);
        end
    endtask

    task automatic test_rst_priority();
        int n = 0;
        while (state_o !== 3'd1 && n < 20) begin tick(); n++; end
        n_vec++; if (state_o !== 3'd1) begin n_err++; $display("FAIL prio_reach_wait got=%0d exp=1", state_o); end
        rst_i = 1'b1; restart_i = 1'b1;
        tick();
        rst_i = 1'b0; restart_i = 1'b0;
        n_vec++;
        if ({state_o, pll_rst_o, ready_o, fail_o, retry_cnt_o, loss_cnt_o} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0}) begin
            n_err++; $display("FAIL prio_reset got state=%0d pll=%b ready=%b fail=%b retry=%0d loss=%0d exp 0/1/0/0/0/0",
                              state_o, pll_rst_o, ready_o, fail_o, retry_cnt_o, loss_cnt_o);
        end
    endtask

    task automatic test_random();
        logic [29:0] got, exp_v;
        int          hold = 0;
        rst_i = 1'b1; restart_i = 1'b0;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            got   = {state_o, pll_rst_o, ready_o, fail_o, retry_cnt_o, loss_cnt_o};
            exp_v = {3'(m_phase), (m_phase == 0) || (m_phase == 4), m_phase == 3, m_phase == 4,
                     8'(m_retries), 16'(m_losses)};
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random cycle %0d got st/pll/rdy/fail/retry/loss=%0d/%b/%b/%b/%0d/%0d exp=%0d/%b/%b/%b/%0d/%0d",
                         i, got[29:27], got[26], got[25], got[24], got[23:16], got[15:0],
                         exp_v[29:27], exp_v[26], exp_v[25], exp_v[24], exp_v[23:16], exp_v[15:0]);
            end
            if (hold == 0) begin
                locked_i = ($urandom % 3) != 0;
                hold = ($urandom % 4 == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            end
            hold--;
            restart_i = ($urandom % 150) == 0;
            rst_i     = ($urandom % 400) == 0;
            tick();
        end
        rst_i = 1'b0; restart_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_no_lock();
        test_stable_glitch();
        test_lock_loss();
        test_restart();
        test_rst_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
